// File: rtl/uart_fifo_bridge.sv
// CPU-side byte FIFOs in front of the buart byte UART: a TX FIFO drained into the UART
// while it is idle, and an RX FIFO filled from the UART and popped by the CPU at leisure.

module uart_fifo_bridge_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH   = LVL_ONE << AW;

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    // A same-cycle pop makes room in a full FIFO; a same-cycle push feeds an empty one.
    assign push_ok = push_i && (!full_q || pop_i);
    assign pop_ok  = pop_i && (!empty_q || push_i);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
        else if (pop_ok && !push_ok) level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == DEPTH);
            empty_q  <= (level_d == '0);
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;
endmodule

module uart_fifo_bridge #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          tx_push,
    input  logic [7:0]    tx_wdata,
    output logic          tx_full,
    output logic [AW:0]   tx_level,
    input  logic          rx_pop,
    output logic [7:0]    rx_rdata,
    output logic          rx_empty,
    output logic [AW:0]   rx_level,
    output logic          rx_overrun,
    input  logic          overrun_clr,
    output logic          uart_wr,
    output logic [7:0]    uart_tx_data,
    input  logic          uart_busy,
    output logic          uart_rd,
    input  logic          uart_valid,
    input  logic [7:0]    uart_rx_data
);
    typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_WAIT} tx_state_e;
    typedef enum logic       {RX_IDLE, RX_HOLD}          rx_state_e;

    tx_state_e  tx_state_q;
    rx_state_e  rx_state_q;
    logic       uart_wr_q, uart_rd_q, rx_overrun_q;
    logic [7:0] uart_tx_data_q;

    logic       tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_take, rx_push, rx_drop;

    uart_fifo_bridge_fifo #(.AW(AW)) u_tx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (tx_push),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    uart_fifo_bridge_fifo #(.AW(AW)) u_rx_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (rx_push),
        .wdata_i (uart_rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign tx_pop  = (tx_state_q == TX_IDLE) && !tx_empty && !uart_busy;
    assign rx_take = (rx_state_q == RX_IDLE) && uart_valid;
    assign rx_push = rx_take && (!rx_full || rx_pop);
    assign rx_drop = rx_take && !rx_push;

    // HOLD spans the cycle before busy rises in response to the wr pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state_q     <= TX_IDLE;
            uart_wr_q      <= 1'b0;
            uart_tx_data_q <= '0;
        end else begin
            uart_wr_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        uart_wr_q      <= 1'b1;
                        uart_tx_data_q <= tx_head;
                        tx_state_q     <= TX_HOLD;
                    end
                end
                TX_HOLD: tx_state_q <= TX_WAIT;
                TX_WAIT: if (!uart_busy) tx_state_q <= TX_IDLE;
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // HOLD masks the stale valid still asserted in the cycle after rd.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_state_q   <= RX_IDLE;
            uart_rd_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            uart_rd_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (uart_valid) begin
                        uart_rd_q  <= 1'b1;
                        rx_state_q <= RX_HOLD;
                    end
                end
                RX_HOLD: rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
            if (overrun_clr)  rx_overrun_q <= 1'b0;
            else if (rx_drop) rx_overrun_q <= 1'b1;
        end
    end

    assign uart_wr      = uart_wr_q;
    assign uart_tx_data = uart_tx_data_q;
    assign uart_rd      = uart_rd_q;
    assign rx_overrun   = rx_overrun_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: a hand-computed vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based model of the bridge behaviour.

module tb_uart_fifo_bridge;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk, resetn;
    logic          tx_push, rx_pop, overrun_clr, uart_busy, uart_valid;
    logic [7:0]    tx_wdata, uart_rx_data, rx_rdata, uart_tx_data;
    logic          tx_full, rx_empty, rx_overrun, uart_wr, uart_rd;
    logic [AW:0]   tx_level, rx_level;

    uart_fifo_bridge #(.AW(AW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tx_push      (tx_push),
        .tx_wdata     (tx_wdata),
        .tx_full      (tx_full),
        .tx_level     (tx_level),
        .rx_pop       (rx_pop),
        .rx_rdata     (rx_rdata),
        .rx_empty     (rx_empty),
        .rx_level     (rx_level),
        .rx_overrun   (rx_overrun),
        .overrun_clr  (overrun_clr),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .uart_busy    (uart_busy),
        .uart_rd      (uart_rd),
        .uart_valid   (uart_valid),
        .uart_rx_data (uart_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rstn;
        logic       push;
        logic [7:0] wd;
        logic       pop;
        logic       valid;
        logic [7:0] rxd;
        logic       busy;
        logic       clr;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic       wr;
        logic [7:0] txd;
        logic       rd;
        logic [5:0] txl;
        logic [5:0] rxl;
        logic       rxe;
        logic       ovr;
        logic [7:0] rdata;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic in_t mk(input logic rstn, input logic push, input logic [7:0] wd,
                               input logic pop, input logic valid, input logic [7:0] rxd,
                               input logic busy, input logic clr);
        in_t r;
        r.rstn = rstn; r.push = push; r.wd = wd; r.pop = pop;
        r.valid = valid; r.rxd = rxd; r.busy = busy; r.clr = clr;
        return r;
    endfunction

    function automatic vec_t mv(input in_t in, input logic wr, input logic [7:0] txd,
                                input logic rd, input logic [5:0] txl, input logic [5:0] rxl,
                                input logic rxe, input logic ovr, input logic [7:0] rdata);
        vec_t v;
        v.in = in; v.wr = wr; v.txd = txd; v.rd = rd; v.txl = txl;
        v.rxl = rxl; v.rxe = rxe; v.ovr = ovr; v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input in_t i);
        resetn       = i.rstn;
        tx_push      = i.push;
        tx_wdata     = i.wd;
        rx_pop       = i.pop;
        uart_valid   = i.valid;
        uart_rx_data = i.rxd;
        uart_busy    = i.busy;
        overrun_clr  = i.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte queues plus the timing rules of the UART handshakes.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovr, m_gap_ok, m_last_acc, e_wr, e_rd;
    logic [7:0] m_txd;
    int         m_edge = 0;
    int         m_last_wr = 0;

    task automatic model_step(input in_t i);
        logic tx_in, psh, popok, drop;
        if (!i.rstn) begin
            txq.delete();
            rxq.delete();
            m_ovr = 1'b0; m_gap_ok = 1'b1; m_last_acc = 1'b0;
            m_txd = 8'h00; e_wr = 1'b0; e_rd = 1'b0;
        end else begin
            // A write needs data, an idle UART, and busy seen low at least two edges after the last write.
            e_wr  = (txq.size() > 0) && !i.busy && m_gap_ok;
            tx_in = i.push && (txq.size() < DEPTH || e_wr);
            if (e_wr) begin
                m_txd     = txq.pop_front();
                m_gap_ok  = 1'b0;
                m_last_wr = m_edge;
            end else if (!m_gap_ok && m_edge >= m_last_wr + 2 && !i.busy) begin
                m_gap_ok = 1'b1;
            end
            if (tx_in) txq.push_back(i.wd);

            e_rd       = i.valid && !m_last_acc;
            m_last_acc = e_rd;
            psh   = e_rd && (rxq.size() < DEPTH || i.pop);
            drop  = e_rd && !psh;
            popok = i.pop && (rxq.size() > 0 || psh);
            if (psh)   rxq.push_back(i.rxd);
            if (popok) void'(rxq.pop_front());
            if (i.clr)     m_ovr = 1'b0;
            else if (drop) m_ovr = 1'b1;
        end
        m_edge++;
    endtask

    task automatic mcycle(input in_t i);
        drive(i);
        model_step(i);
        tick();
        check("uart_wr", 32'(uart_wr), 32'(e_wr));
        check("uart_tx_data", 32'(uart_tx_data), 32'(m_txd));
        check("uart_rd", 32'(uart_rd), 32'(e_rd));
        check("tx_level", 32'(tx_level), 32'(txq.size()));
        check("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
        check("rx_level", 32'(rx_level), 32'(rxq.size()));
        check("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
        check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
        if (rxq.size() > 0) check("rx_rdata", 32'(rx_rdata), 32'(rxq[0]));
    endtask

    // UART busy emulation: one cycle of lag after wr, then ten busy cycles.
    logic busy_lag = 1'b0;
    int   busy_cnt = 0;

    task automatic emu_busy(output logic b);
        b = 1'b0;
        if (busy_lag) busy_lag = 1'b0;
        else if (busy_cnt > 0) begin
            b = 1'b1;
            busy_cnt--;
        end
    endtask

    task automatic emu_update();
        if (uart_wr) begin
            busy_lag = 1'b1;
            busy_cnt = 10;
        end
    endtask

    vec_t tbl[20];

    initial begin
        logic b;

        // rstn push wd pop valid rxd busy clr  ->  wr txd rd txl rxl rxe ovr rdata
        tbl[0]  = mv(mk(0,0,8'h00,0,0,8'h00,0,0), 0,8'h00,0, 0,0,1,0,8'h00);
        tbl[1]  = mv(mk(0,0,8'h00,0,0,8'h00,0,0), 0,8'h00,0, 0,0,1,0,8'h00);
        tbl[2]  = mv(mk(0,0,8'h00,0,0,8'h00,0,0), 0,8'h00,0, 0,0,1,0,8'h00);
        tbl[3]  = mv(mk(1,1,8'h41,0,0,8'h00,0,0), 0,8'h00,0, 1,0,1,0,8'h00);
        tbl[4]  = mv(mk(1,1,8'h42,0,0,8'h00,0,0), 1,8'h41,0, 1,0,1,0,8'h00);
        tbl[5]  = mv(mk(1,1,8'h43,0,0,8'h00,1,0), 0,8'h41,0, 2,0,1,0,8'h00);
        tbl[6]  = mv(mk(1,0,8'h00,0,0,8'h00,1,0), 0,8'h41,0, 2,0,1,0,8'h00);
        tbl[7]  = mv(mk(1,0,8'h00,0,0,8'h00,0,0), 0,8'h41,0, 2,0,1,0,8'h00);
        tbl[8]  = mv(mk(1,0,8'h00,0,0,8'h00,0,0), 1,8'h42,0, 1,0,1,0,8'h00);
        tbl[9]  = mv(mk(1,0,8'h00,0,0,8'h00,1,0), 0,8'h42,0, 1,0,1,0,8'h00);
        tbl[10] = mv(mk(1,0,8'h00,0,0,8'h00,0,0), 0,8'h42,0, 1,0,1,0,8'h00);
        tbl[11] = mv(mk(1,0,8'h00,0,0,8'h00,0,0), 1,8'h43,0, 0,0,1,0,8'h00);
        tbl[12] = mv(mk(1,0,8'h00,0,0,8'h00,0,0), 0,8'h43,0, 0,0,1,0,8'h00);
        tbl[13] = mv(mk(1,0,8'h00,0,1,8'h55,0,0), 0,8'h43,1, 0,1,0,0,8'h55);
        tbl[14] = mv(mk(1,0,8'h00,0,1,8'h55,0,0), 0,8'h43,0, 0,1,0,0,8'h55);
        tbl[15] = mv(mk(1,0,8'h00,1,0,8'h00,0,0), 0,8'h43,0, 0,0,1,0,8'h00);
        tbl[16] = mv(mk(1,0,8'h00,1,1,8'h66,0,0), 0,8'h43,1, 0,0,1,0,8'h00);
        tbl[17] = mv(mk(1,0,8'h00,0,1,8'h77,0,0), 0,8'h43,0, 0,0,1,0,8'h00);
        tbl[18] = mv(mk(1,0,8'h00,0,1,8'h77,0,0), 0,8'h43,1, 0,1,0,0,8'h77);
        tbl[19] = mv(mk(0,0,8'h00,0,0,8'h00,0,0), 0,8'h00,0, 0,0,1,0,8'h00);

        drive(tbl[0].in);
        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].in);
            tick();
            check($sformatf("row%0d uart_wr", k), 32'(uart_wr), 32'(tbl[k].wr));
            check($sformatf("row%0d uart_tx_data", k), 32'(uart_tx_data), 32'(tbl[k].txd));
            check($sformatf("row%0d uart_rd", k), 32'(uart_rd), 32'(tbl[k].rd));
            check($sformatf("row%0d tx_level", k), 32'(tx_level), 32'(tbl[k].txl));
            check($sformatf("row%0d tx_full", k), 32'(tx_full), 32'(tbl[k].txl == 6'(DEPTH)));
            check($sformatf("row%0d rx_level", k), 32'(rx_level), 32'(tbl[k].rxl));
            check($sformatf("row%0d rx_empty", k), 32'(rx_empty), 32'(tbl[k].rxe));
            check($sformatf("row%0d rx_overrun", k), 32'(rx_overrun), 32'(tbl[k].ovr));
            if (!tbl[k].rxe) check($sformatf("row%0d rx_rdata", k), 32'(rx_rdata), 32'(tbl[k].rdata));
        end

        // TX full with busy held high, then drain against an emulated UART.
        for (int k = 0; k < 3; k++) mcycle(mk(0,0,8'h00,0,0,8'h00,0,0));
        for (int k = 0; k < 17; k++) mcycle(mk(1,1,8'(8'h10 + k),0,0,8'h00,1,0));
        check("tx_full_after_17", 32'(tx_full), 32'd1);
        check("tx_level_after_17", 32'(tx_level), 32'd16);
        busy_lag = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 260; k++) begin
            emu_busy(b);
            mcycle(mk(1,0,8'h00,0,0,8'h00,b,0));
            emu_update();
        end
        check("tx_drained", 32'(tx_level), 32'd0);

        // RX fill, overrun, clear precedence, full-with-pop acceptance.
        for (int k = 0; k < 2; k++) mcycle(mk(0,0,8'h00,0,0,8'h00,0,0));
        for (int k = 0; k < 16; k++) begin
            mcycle(mk(1,0,8'h00,0,1,8'(8'h80 + k),0,0));
            mcycle(mk(1,0,8'h00,0,0,8'h00,0,0));
        end
        mcycle(mk(1,0,8'h00,0,1,8'hAA,0,0));
        check("overrun_set", 32'(rx_overrun), 32'd1);
        mcycle(mk(1,0,8'h00,0,0,8'h00,0,0));
        mcycle(mk(1,0,8'h00,0,1,8'hAB,0,1));
        mcycle(mk(1,0,8'h00,0,0,8'h00,0,0));
        mcycle(mk(1,0,8'h00,1,1,8'hAA,0,0));
        mcycle(mk(1,0,8'h00,0,0,8'h00,0,0));
        mcycle(mk(1,0,8'h00,0,1,8'hCC,0,0));
        mcycle(mk(1,0,8'h00,0,0,8'h00,0,1));
        for (int k = 0; k < 20; k++) mcycle(mk(1,0,8'h00,1,0,8'h00,0,0));

        // Interleaved traffic across pointer wrap with same-cycle push/pop.
        for (int k = 0; k < 2; k++) mcycle(mk(0,0,8'h00,0,0,8'h00,0,0));
        for (int k = 0; k < 4; k++) mcycle(mk(1,1,8'(8'hC0 + k),0,0,8'h00,1,0));
        for (int k = 0; k < 10; k++) mcycle(mk(1,0,8'h00,0,(k % 2 == 0),8'(8'hD0 + k),1,0));
        for (int k = 0; k < 40; k++)
            mcycle(mk(1,(k % 3 == 0),8'(8'h20 + k),(k % 2 == 0),(k % 2 == 0),8'(8'h60 + k),0,0));

        // Randomized traffic with occasional mid-stream reset.
        for (int k = 0; k < 600; k++) begin
            in_t r;
            r.rstn  = ($urandom_range(0, 149) != 0);
            r.push  = ($urandom_range(0, 99) < 60);
            r.wd    = 8'($urandom);
            r.pop   = ($urandom_range(0, 99) < ((k < 300) ? 15 : 55));
            r.valid = ($urandom_range(0, 99) < 60);
            r.rxd   = 8'($urandom);
            r.busy  = ($urandom_range(0, 99) < 40);
            r.clr   = ($urandom_range(0, 99) < 8);
            mcycle(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
